// File: rtl/snake_head_mover.sv
// snake_head_mover: owns the snake head position and committed direction.
// Steps the head one cell per game tick while running. It freezes into DEAD
// when the collision detector reports a wall hit for the current head position.
module snake_head_mover #(
  parameter int         GRID_COLS = 160,
  parameter int         GRID_ROWS = 120,
  parameter int         START_X   = 80,
  parameter int         START_Y   = 60,
  parameter logic [1:0] START_DIR = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       tick,
  input  logic       dir_req_valid,
  input  logic [1:0] dir_req,
  input  logic       hit_wall,
  output logic [7:0] head_x,
  output logic [6:0] head_y,
  output logic [1:0] dir,
  output logic       step_valid,
  output logic       running,
  output logic       dead
);

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  localparam logic [7:0] X_MAX = 8'(GRID_COLS - 1);
  localparam logic [6:0] Y_MAX = 7'(GRID_ROWS - 1);
  localparam logic [7:0] X0    = 8'(START_X);
  localparam logic [6:0] Y0    = 7'(START_Y);

  state_t     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [1:0] dir_q, dir_d;
  logic [1:0] pend_q, pend_d;
  logic       step_d;

  // A request opposite to the committed direction would fold the snake onto
  // itself, so it is dropped rather than queued.
  logic       req_legal;
  logic [1:0] eff_dir;
  assign req_legal = dir_req_valid && (dir_req != (dir_q ^ 2'b10));
  assign eff_dir   = req_legal ? dir_req : pend_q;

  // Next-state, direction bookkeeping and saturating head step.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    step_d  = 1'b0;

    if (start) begin
      state_d = RUN;
      x_d     = X0;
      y_d     = Y0;
      dir_d   = START_DIR;
      pend_d  = START_DIR;
    end else begin
      unique case (state_q)
        RUN: begin
          if (hit_wall) begin
            state_d = DEAD;
          end else begin
            pend_d = eff_dir;
            if (tick) begin
              dir_d  = eff_dir;
              step_d = 1'b1;
              unique case (eff_dir)
                DIR_RIGHT: x_d = (x_q >= X_MAX) ? X_MAX : x_q + 8'd1;
                DIR_LEFT:  x_d = (x_q == 8'd0)  ? 8'd0  : x_q - 8'd1;
                DIR_DOWN:  y_d = (y_q >= Y_MAX) ? Y_MAX : y_q + 7'd1;
                DIR_UP:    y_d = (y_q == 7'd0)  ? 7'd0  : y_q - 7'd1;
                default:   ;
              endcase
            end
          end
        end
        default: ;  // IDLE and DEAD hold everything until start
      endcase
    end
  end

  // State and datapath registers; outputs are driven straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= X0;
      y_q        <= Y0;
      dir_q      <= START_DIR;
      pend_q     <= START_DIR;
      step_valid <= 1'b0;
      running    <= 1'b0;
      dead       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      pend_q     <= pend_d;
      step_valid <= step_d;
      running    <= (state_d == RUN);
      dead       <= (state_d == DEAD);
    end
  end

  assign head_x = x_q;
  assign head_y = y_q;
  assign dir    = dir_q;

endmodule

// File: doc/snake_head_mover.md
# snake_head_mover

Sequential producer of the snake head position consumed by the wall collision detector. On each game tick while running, it commits the latest legal direction request and moves the head one grid cell. It takes `hit_wall` back from the detector and freezes into a DEAD state. It sits between the input/controller logic, which supplies direction requests and `start`, and the collision/render path, which consumes `head_x`/`head_y`.

## Interface
- `GRID_COLS`, default `GRID_COLS` from defs.vh (160): grid width in cells.
- `GRID_ROWS`, default `GRID_ROWS` from defs.vh (120): grid height in cells.
- `START_X`, default 80: head x after reset/start.
- `START_Y`, default 60: head y after reset/start.
- `START_DIR`, default 2'b00: initial direction.
- `clk`  in  1  single system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse; (re)starts a game from any state.
- `tick`  in  1  one-cycle game-step strobe.
- `dir_req_valid`  in  1  direction request strobe.
- `dir_req`  in  2  requested direction: 00 right, 01 down, 10 left, 11 up.
- `hit_wall`  in  1  from collision detector; combinational function of `head_x`/`head_y`.
- `head_x`  out  8  registered head column.
- `head_y`  out  7  registered head row.
- `dir`  out  2  committed direction, same encoding as `dir_req`.
- `step_valid`  out  1  one-cycle pulse in the cycle after the head moved.
- `running`  out  1  high in RUN.
- `dead`  out  1  high in DEAD.

## Operation
- FSM states: IDLE, RUN, DEAD. Reset enters IDLE.
- IDLE: head held at (`START_X`, `START_Y`). `tick`, `dir_req_valid` and `hit_wall` are ignored.
- `start` in any state:
  - Load head = (`START_X`, `START_Y`), `dir` = `pending_dir` = `START_DIR`.
  - Enter RUN. No move occurs that cycle.
- RUN, direction request:
  - `dir_req_valid` writes `pending_dir` = `dir_req` unless `dir_req == dir ^ 2'b10`, which is a reversal against the committed `dir`. Reversals are dropped.
  - Multiple requests between ticks: last legal one wins.
  - A request and a `tick` in the same cycle: the request is applied before the commit, so the tick uses it.
- RUN, `tick` with `hit_wall`=0:
  - `dir` <= effective pending direction.
  - Head steps one cell: right x+1, down y+1, left x−1, up y−1.
  - `step_valid` = 1 next cycle.
- RUN, `hit_wall`=1 (any cycle, with or without `tick`): enter DEAD. Head and `dir` are frozen and no move occurs. `hit_wall` has priority over `tick`.
- DEAD: everything is frozen until `start`. `dir_req_valid` and `tick` are ignored.
- Arithmetic: next-coordinate saturates to 0..`GRID_COLS`−1 and 0..`GRID_ROWS`−1. Decrement at 0 stays 0; increment at max stays max. There is no wrap-around. In normal play the wall hit stops motion before saturation is reached.
- Precedence per cycle: `start` > `hit_wall` > `tick`.

## Timing
- Reset values (async, immediate):
  - `head_x`=`START_X`, `head_y`=`START_Y`
  - `dir`=`START_DIR`, `pending_dir`=`START_DIR`
  - `step_valid`=0, `running`=0, `dead`=0
- Tick in cycle N moves the head at edge N+1. `step_valid`=1 during cycle N+1.
- `hit_wall` for the new position is valid during cycle N+1. If it is 1, `dead`=1 from cycle N+2.
- `start` in cycle N gives `running`=1 and the start position from cycle N+1. The first move happens on the first `tick` at cycle ≥ N+1.
- All outputs are registered. No combinational path from `hit_wall` to any output, so the detector loop is safe.
- Reset mid-game aborts to IDLE asynchronously. Pending state is discarded.

## Test plan
- Reset, then `start`, then 3 ticks with no requests → head (81,60), (82,60), (83,60). `step_valid` pulses 3 times; `dir`=00.
- RUN facing right; `dir_req`=10 (reversal) then `tick` → request dropped, head x+1, `dir` stays 00. Then `dir_req`=11 and `tick` in the same cycle → `dir`=11, head y−1.
- Two requests between ticks (01 then 11, starting from `dir`=00) → next tick commits 11 and y decrements.
- Move up from y=60 with 60 ticks → at y=0 `hit_wall`=1 and `dead`=1 one cycle later. A further tick leaves head (x,0) and no `step_valid` occurs.
- In DEAD, assert `start` together with `tick` → head (80,60), `dir`=00, `running`=1, no move that cycle.
- Assert `rst_n`=0 mid-RUN at head (100,40) → outputs return to reset values immediately, without waiting for a clock edge; state is IDLE.
